// File: rtl/transform_pkg.sv
// Shared constants and entry-index mapping for the 4x4 transform ping-pong register file.
package transform_pkg;

   localparam int unsigned DW_DEF    = 16;
   localparam int unsigned OW_DEF    = 9;
   localparam int unsigned RND_OFS   = 32;
   localparam int unsigned RND_SHIFT = 6;
   localparam int unsigned LANES     = 4;
   localparam int unsigned ENTRIES   = 16;

   // Row access walks entries 4*idx+k, column access walks 4*k+idx.
   function automatic logic [3:0] entry_idx(input logic col, input logic [1:0] idx,
                                            input logic [1:0] k);
      return col ? {k, idx} : {idx, k};
   endfunction

endpackage

// File: rtl/transform_round.sv
// One-lane round-and-saturate: y = sat_OW((x + 32) >>> 6), sign-extended to DW.
// Rounding exists only when TRANSFORM_PINGPONG_ROUND_EN is defined; otherwise x passes through.
module transform_round
   import transform_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned OW = OW_DEF
) (
   input  logic          en,
   input  logic [DW-1:0] x,
   output logic [DW-1:0] y_c
);

`ifdef TRANSFORM_PINGPONG_ROUND_EN
   localparam int unsigned XW = DW + 1;
   localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (OW - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [XW-1:0] sum;
   logic signed [XW-1:0] shf;
   logic signed [XW-1:0] sat;

   // One extra bit of headroom keeps x + offset from wrapping.
   always_comb begin
      sum = $signed({x[DW-1], x}) + $signed(XW'(RND_OFS));
      shf = sum >>> RND_SHIFT;
      if (shf > SAT_MAX)
         sat = SAT_MAX;
      else if (shf < SAT_MIN)
         sat = SAT_MIN;
      else
         sat = shf;
      y_c = en ? DW'(sat) : x;
   end
`else
   logic unused_en;
   assign unused_en = en;
   assign y_c       = x;
`endif

endmodule

// File: rtl/transform_pingpong_regs.sv
// Two-bank 4x4 ping-pong register file with row/column access, DC fill and optional rounding.
// Optional rounding is enabled by defining TRANSFORM_PINGPONG_ROUND_EN.
module transform_pingpong_regs
   import transform_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned OW = OW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               clr,
   input  logic               wr_en,
   input  logic               wr_col,
   input  logic [1:0]         wr_idx,
   input  logic               wr_round,
   input  logic [4*DW-1:0]    wr_data,
   input  logic               dc_fill,
   input  logic [DW-1:0]      dc_in,
   input  logic               wr_done,
   output logic               wr_ready,
   input  logic               rd_en,
   input  logic               rd_col,
   input  logic [1:0]         rd_idx,
   output logic [4*DW-1:0]    rd_data,
   output logic               rd_valid,
   input  logic               rd_release,
   output logic [16*OW-1:0]   pix_out,
   output logic               err
);

   logic [DW-1:0] bank [2][ENTRIES];
   logic          wp;
   logic          rp;
   logic [1:0]    cnt;

   logic [DW-1:0]   lane_c [LANES];
   logic [DW-1:0]   fill_c;
   logic [DW-1:0]   rd_lane_c [LANES];
   logic [4*DW-1:0] rd_word_c;
   logic            done_ok_c;
   logic            rel_ok_c;
   logic            fill_hit_c;
   logic            row_hit_c;
   logic            proto_err_c;
   logic [1:0]      cnt_nxt_c;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      transform_round #(.DW(DW), .OW(OW)) u_lane (
         .en  (wr_round),
         .x   (wr_data[k*DW +: DW]),
         .y_c (lane_c[k])
      );
   end

   transform_round #(.DW(DW), .OW(OW)) u_dc (
      .en  (1'b1),
      .x   (dc_in),
      .y_c (fill_c)
   );

   // Commit/release decode, occupancy next state and read-lane gather.
   always_comb begin
      done_ok_c   = wr_done && wr_ready;
      rel_ok_c    = rd_release && rd_valid;
      fill_hit_c  = dc_fill && wr_ready;
      row_hit_c   = wr_en && wr_ready && !dc_fill;
      proto_err_c = ((dc_fill || wr_en) && !wr_ready) ||
                    (wr_done && !wr_ready) ||
                    (rd_release && !rd_valid);
      cnt_nxt_c   = cnt;
      case ({done_ok_c, rel_ok_c})
         2'b10:   cnt_nxt_c = cnt + 2'd1;
         2'b01:   cnt_nxt_c = cnt - 2'd1;
         default: cnt_nxt_c = cnt;
      endcase
      rd_word_c = '0;
      for (int k = 0; k < LANES; k++) begin
         rd_lane_c[k]             = bank[rp][entry_idx(rd_col, rd_idx, 2'(k))];
         rd_word_c[k*DW +: DW]    = rd_lane_c[k];
      end
   end

   // Read-bank entries exposed as truncated pixels.
   always_comb begin
      pix_out = '0;
      for (int e = 0; e < ENTRIES; e++)
         pix_out[e*OW +: OW] = bank[rp][e][OW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int e = 0; e < ENTRIES; e++)
               bank[b][e] <= '0;
         wp       <= 1'b0;
         rp       <= 1'b0;
         cnt      <= 2'd0;
         wr_ready <= 1'b1;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         err      <= 1'b0;
      end else if (ena) begin
         if (clr) begin
            for (int b = 0; b < 2; b++)
               for (int e = 0; e < ENTRIES; e++)
                  bank[b][e] <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= 2'd0;
            wr_ready <= 1'b1;
            rd_valid <= 1'b0;
            err      <= 1'b0;
         end else begin
            // A write lands in bank wp even when that bank commits this cycle.
            if (fill_hit_c) begin
               for (int e = 0; e < ENTRIES; e++)
                  bank[wp][e] <= fill_c;
            end else if (row_hit_c) begin
               for (int k = 0; k < LANES; k++)
                  bank[wp][entry_idx(wr_col, wr_idx, 2'(k))] <= lane_c[k];
            end
            wp       <= wp ^ done_ok_c;
            rp       <= rp ^ rel_ok_c;
            cnt      <= cnt_nxt_c;
            wr_ready <= (cnt_nxt_c != 2'd2);
            rd_valid <= (cnt_nxt_c != 2'd0);
            if (proto_err_c)
               err <= 1'b1;
            if (rd_en)
               rd_data <= rd_word_c;
         end
      end
   end

endmodule
